chip8_audio_pwm: RTL

Consumer end of the chip8 audio sample stream. Accepts 8-bit unsigned samples (0x80 = midpoint/silence) from the audio generator through a valid/ready handshake into a small FIFO. Pops one sample per sample period and drives a 1-bit PWM pin for an external RC-filtered audio output. Sits between the chip8 audio generator and the top-level audio pin.

---
 rtl/chip8_audio_pwm.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/chip8_audio_pwm.sv
// -----------------------------------------------------------------------------
// chip8_audio_pwm
//
// Audio sink for the chip8 sample stream. 8-bit unsigned samples (8'h80 is
// silence) arrive over a valid/ready handshake into a small FIFO. One sample
// is popped per sample period and rendered onto a single pin for an external
// RC low-pass filter.
//
// Default build: 8-bit PWM. The duty cycle latches only at frame boundaries,
// so a new sample never produces a runt pulse.
// With CHIP8_AUDIO_DSM_EN defined: a first-order delta-sigma modulator
// replaces the PWM comparator. It tracks level changes on the next cycle.
//
// Parameters:
//   CLK_PER_SAMPLE  clk_in cycles per sample period (>= 2)
//   FIFO_DEPTH      sample FIFO entries (power of 2, >= 2)
//
// Ports:
//   clk_in            system clock
//   rst_n_in          synchronous reset, active-low
//   sample_in         unsigned audio sample
//   sample_valid_in   sample_in valid
//   sample_ready_out  FIFO not full (held low during reset)
//   enable_in         0 mutes the pin (held low)
//   pwm_out           registered modulated audio bit
//   fifo_count_out    current FIFO occupancy
//   sample_tick_out   one-cycle pulse per sample-period boundary
//   underrun_out      one-cycle pulse when a tick finds the FIFO empty
// -----------------------------------------------------------------------------
module chip8_audio_pwm #(
    parameter int CLK_PER_SAMPLE = 2272,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                          clk_in,
    input  logic                          rst_n_in,
    input  logic [7:0]                    sample_in,
    input  logic                          sample_valid_in,
    output logic                          sample_ready_out,
    input  logic                          enable_in,
    output logic                          pwm_out,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_out,
    output logic                          sample_tick_out,
    output logic                          underrun_out
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(CLK_PER_SAMPLE);

    localparam logic [TW-1:0] TICK_LAST  = TW'(CLK_PER_SAMPLE - 1);
    localparam logic [CW-1:0] COUNT_FULL = CW'(FIFO_DEPTH);

    // Sample storage and FIFO bookkeeping
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    // Sample-period timing
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic          tick_out_q, tick_out_d;
    logic          underrun_q, underrun_d;

    // Current output level and modulator output
    logic [7:0]    level_q, level_d;
    logic          pwm_q, pwm_d;

`ifdef CHIP8_AUDIO_DSM_EN
    logic [7:0]    acc_q, acc_d;
    logic [8:0]    dsm_sum_s;
`else
    logic [7:0]    pwm_cnt_q, pwm_cnt_d;
    logic [7:0]    frame_q, frame_d;
`endif

    logic tick_s;
    logic push_s;
    logic pop_s;

    // Ready is derived from the registered count; it is gated by reset so a
    // source never sees a stale ready while the block is being cleared.
    assign sample_ready_out = rst_n_in && (count_q != COUNT_FULL);
    assign fifo_count_out   = count_q;
    assign sample_tick_out  = tick_out_q;
    assign underrun_out     = underrun_q;
    assign pwm_out          = pwm_q;

    // Handshake, tick and FIFO next-state logic
    always_comb begin
        tick_s = (tick_cnt_q == TICK_LAST);
        push_s = sample_valid_in && sample_ready_out;
        // A pop looks only at the registered count. A push on the same
        // cycle into an empty FIFO is stored, not bypassed to the output.
        pop_s  = tick_s && (count_q != {CW{1'b0}});

        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        level_d    = level_q;
        tick_cnt_d = tick_cnt_q;

        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PW'(1'b1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1'b1);
            level_d  = mem_q[rd_ptr_q];
        end else begin
            rd_ptr_d = rd_ptr_q;
            level_d  = level_q;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1'b1);
            2'b01:   count_d = count_q - CW'(1'b1);
            default: count_d = count_q;
        endcase

        if (tick_s) begin
            tick_cnt_d = {TW{1'b0}};
        end else begin
            tick_cnt_d = tick_cnt_q + TW'(1'b1);
        end

        tick_out_d = tick_s;
        underrun_d = tick_s && (count_q == {CW{1'b0}});
    end

`ifdef CHIP8_AUDIO_DSM_EN
    // Delta-sigma modulator: the carry out of the level accumulator is the bit
    // stream, so L carries occur in every 256 cycles of constant level L.
    always_comb begin
        dsm_sum_s = {1'b0, acc_q} + {1'b0, level_q};
        acc_d     = dsm_sum_s[7:0];
        pwm_d     = enable_in && dsm_sum_s[8];
    end
`else
    // PWM comparator: the frame level is re-latched only at the last count.
    // Duty changes therefore take effect on a clean frame boundary.
    always_comb begin
        pwm_cnt_d = pwm_cnt_q + 8'd1;
        if (pwm_cnt_q == 8'hFF) begin
            frame_d = level_q;
        end else begin
            frame_d = frame_q;
        end
        pwm_d = enable_in && (pwm_cnt_q < frame_q);
    end
`endif

    // FIFO storage; write-only on an accepted push, no reset needed
    always_ff @(posedge clk_in) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= sample_in;
        end
    end

    // Common state registers with synchronous active-low reset
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            wr_ptr_q   <= {PW{1'b0}};
            rd_ptr_q   <= {PW{1'b0}};
            count_q    <= {CW{1'b0}};
            tick_cnt_q <= {TW{1'b0}};
            tick_out_q <= 1'b0;
            underrun_q <= 1'b0;
            level_q    <= 8'h80;
            pwm_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            tick_cnt_q <= tick_cnt_d;
            tick_out_q <= tick_out_d;
            underrun_q <= underrun_d;
            level_q    <= level_d;
            pwm_q      <= pwm_d;
        end
    end

`ifdef CHIP8_AUDIO_DSM_EN
    // Modulator accumulator register
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            acc_q <= 8'h00;
        end else begin
            acc_q <= acc_d;
        end
    end
`else
    // PWM counter and frame-level registers
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            pwm_cnt_q <= 8'h00;
            frame_q   <= 8'h80;
        end else begin
            pwm_cnt_q <= pwm_cnt_d;
            frame_q   <= frame_d;
        end
    end
`endif

endmodule
